// File: rtl/tt_um_jimktrains_vslc_scan_fetch.sv
// Scan-cycle instruction fetcher: streams the ladder program from SPI NOR flash (READ 0x03)
// and provides per-scan input snapshots to the VSLC executor.
module tt_um_jimktrains_vslc_scan_fetch #(
  parameter logic [23:0] PROG_BASE      = 24'h000000,
  parameter int unsigned PROG_LEN_MAX   = 256,
  parameter int unsigned CS_IDLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic       spi_miso,
  output logic       spi_cs_n,
  output logic       spi_sck,
  output logic       spi_mosi,
  output logic [7:0] instr,
  output logic       instr_ready,
  output logic [7:0] ui_in_scan,
  output logic [7:0] ui_in_prev,
  output logic       scan_start,
  output logic [7:0] pc
);

  localparam int unsigned GapW    = (CS_IDLE_CYCLES > 1) ? $clog2(CS_IDLE_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(CS_IDLE_CYCLES - 1);
  localparam logic [7:0]  PcLast  = 8'(PROG_LEN_MAX - 1);
  localparam logic [31:0] CmdAddr = {8'h03, PROG_BASE};

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StGap} state_e;

  state_e            state_q;
  logic [7:0]        sync1_q;
  logic [7:0]        sync2_q;
  logic [31:0]       tx_q;
  logic [7:0]        rx_q;
  logic [4:0]        bit_q;
  logic [GapW-1:0]   gap_q;
  logic              last_q;

  logic              start;
  logic [7:0]        rx_byte;

  // The final gap cycle behaves like IDLE so a new scan can begin without an extra cycle.
  assign start   = ena && ((state_q == StIdle) || ((state_q == StGap) && (gap_q == GapLast)));
  assign rx_byte = {rx_q[6:0], spi_miso};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sync1_q     <= 8'h00;
      sync2_q     <= 8'h00;
      tx_q        <= 32'h0;
      rx_q        <= 8'h00;
      bit_q       <= 5'd0;
      gap_q       <= '0;
      last_q      <= 1'b0;
      spi_cs_n    <= 1'b1;
      spi_sck     <= 1'b0;
      spi_mosi    <= 1'b0;
      instr       <= 8'h00;
      instr_ready <= 1'b0;
      ui_in_scan  <= 8'h00;
      ui_in_prev  <= 8'h00;
      scan_start  <= 1'b0;
      pc          <= 8'h00;
    end else begin
      sync1_q     <= ui_in;
      sync2_q     <= sync1_q;
      scan_start  <= 1'b0;
      instr_ready <= 1'b0;
      if (start) begin
        state_q    <= StCmd;
        spi_cs_n   <= 1'b0;
        spi_sck    <= 1'b0;
        spi_mosi   <= CmdAddr[31];
        tx_q       <= {CmdAddr[30:0], 1'b0};
        bit_q      <= 5'd0;
        last_q     <= 1'b0;
        scan_start <= 1'b1;
        ui_in_prev <= ui_in_scan;
        ui_in_scan <= sync2_q;
        pc         <= 8'h00;
      end else begin
        case (state_q)
          StIdle: begin
            spi_cs_n <= 1'b1;
          end
          StCmd, StAddr: begin
            if (!spi_sck) begin
              spi_sck <= 1'b1;
            end else begin
              spi_sck  <= 1'b0;
              spi_mosi <= tx_q[31];
              tx_q     <= {tx_q[30:0], 1'b0};
              bit_q    <= bit_q + 5'd1;
              if ((state_q == StCmd) && (bit_q == 5'd7)) begin
                state_q <= StAddr;
                bit_q   <= 5'd0;
              end else if ((state_q == StAddr) && (bit_q == 5'd23)) begin
                state_q  <= StData;
                bit_q    <= 5'd0;
                spi_mosi <= 1'b0;
              end
            end
          end
          StData: begin
            if (last_q) begin
              // Length limit reached: the strobe cycle has passed, drop the transaction.
              state_q  <= StGap;
              gap_q    <= '0;
              spi_cs_n <= 1'b1;
              last_q   <= 1'b0;
            end else if (!spi_sck) begin
              spi_sck <= 1'b1;
            end else begin
              spi_sck <= 1'b0;
              rx_q    <= rx_byte;
              bit_q   <= bit_q + 5'd1;
              if (bit_q == 5'd7) begin
                bit_q <= 5'd0;
                if (rx_byte == 8'hFF) begin
                  state_q  <= StGap;
                  gap_q    <= '0;
                  spi_cs_n <= 1'b1;
                end else begin
                  instr       <= rx_byte;
                  instr_ready <= 1'b1;
                  pc          <= pc + 8'd1;
                  last_q      <= (pc == PcLast);
                end
              end
            end
          end
          StGap: begin
            if (gap_q == GapLast) begin
              state_q <= StIdle;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/tt_um_jimktrains_vslc_scan_fetch.md
# tt_um_jimktrains_vslc_scan_fetch

Scan-cycle instruction fetcher sitting directly upstream of the VSLC executor. Streams the ladder program byte-by-byte from an external SPI NOR flash (READ 0x03) and presents each byte on `instr` with a one-cycle `instr_ready` strobe. Also provides the executor's per-scan input snapshot (`ui_in_scan`) and the previous snapshot (`ui_in_prev`), so edge-detect instructions see stable inputs for a whole scan. The scan ends on an end-of-program byte or on a length limit, then restarts.

## Interface
- `PROG_BASE`, 24'h000000, flash byte address of the first instruction
- `PROG_LEN_MAX`, 256, maximum instructions per scan (1..256)
- `CS_IDLE_CYCLES`, 4, clk cycles `spi_cs_n` stays high between scans (>=1)

- `clk`  in  1  system clock; one clock domain; all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `ena`  in  1  run enable
- `ui_in`  in  8  raw inputs, asynchronous to clk
- `spi_miso`  in  1  flash data out
- `spi_cs_n`  out  1  flash chip select
- `spi_sck`  out  1  SPI clock, mode 0, clk/2
- `spi_mosi`  out  1  flash data in
- `instr`  out  8  current instruction byte
- `instr_ready`  out  1  one-cycle strobe: `instr` is new and valid
- `ui_in_scan`  out  8  input snapshot for the current scan
- `ui_in_prev`  out  8  snapshot of the previous scan
- `scan_start`  out  1  one-cycle pulse at scan start
- `pc`  out  8  instructions emitted this scan (wraps 256 to 0)

## Operation
- Reset values: `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `instr`=0, `instr_ready`=0, `ui_in_scan`=0, `ui_in_prev`=0, `scan_start`=0, `pc`=0, state IDLE, synchroniser flops 0.
- `ui_in` passes through a 2-flop synchroniser; snapshots take the synchronised value.
- States: IDLE, CMD (8 bits), ADDR (24 bits, MSB first, `PROG_BASE`), DATA (8-bit bytes, streamed continuously), GAP.
- IDLE -> CMD when `ena`=1: `spi_cs_n` falls, `scan_start`=1, `ui_in_prev`<=`ui_in_scan`, `ui_in_scan`<=synchronised `ui_in`, `pc`<=0. All take effect on the same edge.
- Each SPI bit uses 2 clk cycles: a low phase (`spi_sck`=0, `spi_mosi` updated) and a high phase (`spi_sck`=1). `spi_miso` is sampled on the clk edge that ends the high phase.
- CMD shifts 0x03 MSB first; ADDR shifts `PROG_BASE`; DATA drives `spi_mosi`=0.
- When a data byte completes: if byte != 0xFF, `instr`<=byte, `instr_ready`=1 for one cycle, `pc`++. The next byte's first bit starts in that same cycle, with no gap.
- End of scan: byte == 0xFF (not emitted, `instr` unchanged), or `PROG_LEN_MAX` bytes emitted. Either way the next cycle has `spi_cs_n`=1 and state GAP.
- GAP lasts `CS_IDLE_CYCLES` cycles, then IDLE. IDLE re-enters CMD the same cycle if `ena`=1.
- `ena` is sampled only in IDLE. Deasserting it mid-scan lets the scan finish; the block then waits in IDLE.
- `rst_n` low mid-transfer: all outputs go to reset values immediately (asynchronous). The flash transaction is aborted by `spi_cs_n`=1.

## Timing
- Cycle 0 = first cycle with `spi_cs_n`=0. CMD+ADDR occupy cycles 0..63; byte k occupies cycles 64+16k .. 79+16k.
- `instr_ready` for byte k is high in cycle 80+16k. `instr` is stable from that cycle until the next strobe, so it is safe for negedge sampling by the executor.
- Byte period: 16 cycles. Executor must accept one instruction per 16 cycles; there is no backpressure.
- Scan with N emitted bytes ended by 0xFF: `spi_cs_n` high from cycle 80+16N. The next `scan_start` comes at cycle 80+16N+`CS_IDLE_CYCLES` if `ena`=1.
- Scan ended by the length limit (N=`PROG_LEN_MAX`): `spi_cs_n` high from cycle 81+16(N-1).
- Input latency: a `ui_in` change is captured in `ui_in_scan` if it is stable for 2 cycles before `scan_start`.

## Test plan
- Reset: hold `rst_n`=0 with `ena`=1 and random `spi_miso` -> every output equals its reset value. Release -> `scan_start` and `spi_cs_n` fall on the first edge.
- Fetch: flash model with `PROG_BASE`=0 holding 0x00,0x10,0xFF -> MOSI carries 0x03 then 24'h0. `instr_ready` appears at cycle 80 (0x00, `pc`=1) and cycle 96 (0x10, `pc`=2). No strobe for 0xFF. `spi_cs_n` high cycles 112..115. Next `scan_start` at cycle 116.
- Length limit: `PROG_LEN_MAX`=4 with flash full of 0x81 -> exactly 4 strobes at cycles 80, 96, 112, 128. `spi_cs_n` high at cycle 129.
- Snapshots: `ui_in`=0x5A before scan 1 and 0xA5 before scan 2 -> during scan 2, `ui_in_scan`=0xA5 and `ui_in_prev`=0x5A. A `ui_in` change mid-scan does not alter `ui_in_scan`.
- Enable: drop `ena` at cycle 90 of a 2-byte program -> the scan completes normally; the block then stays in IDLE with `spi_cs_n`=1. Raising `ena` -> `scan_start` on the next edge.
- Reset mid-byte: assert `rst_n`=0 at cycle 70 -> `spi_cs_n`=1 without waiting for a clk edge. After release, a fresh scan begins from CMD with `pc`=0.
